// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run controller.
//   run_state_e  - FSM state encoding, also exported on state_o
//   RST_CNT_W    - reset-hold counter width for the default hold length
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CORE_RST    = 3'd1,
    LOAD_REQ    = 3'd2,
    LOAD_WAIT   = 3'd3,
    WAIT_UNHALT = 3'd4,
    RUN         = 3'd5,
    PAUSE       = 3'd6,
    DONE        = 3'd7
  } run_state_e;

  localparam int RST_CYCLES_DEF = 8;
  localparam int RST_CNT_W      = $clog2(RST_CYCLES_DEF + 1);

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: DMA request channel between the run controller and the DMA engine.
//   dma_req/dma_addr/dma_size : request from the controller (master)
//   dma_ack                   : engine accepted the request
//   dma_done                  : transfer complete pulse
interface run_ctrl_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 16
) ();
  logic                  dma_req;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [SIZE_WIDTH-1:0] dma_size;
  logic                  dma_ack;
  logic                  dma_done;

  modport master (output dma_req, dma_addr, dma_size, input dma_ack, dma_done);
  modport slave  (input dma_req, dma_addr, dma_size, output dma_ack, dma_done);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clr   : synchronous clear (wins over en)
//   en    : count enable
//   count : current value
module sat_counter #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !(&count))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences the accelerator core from MMIO control values.
// Holds the core in reset, loads the program image by one DMA request,
// releases reset, gates execution with unhalt and counts run cycles until
// halt or timeout.
//   go/soft_reset/unhalt/start_addr/prog_size : MMIO control inputs
//   dma                                       : DMA request channel (master)
//   core_rst/core_run/core_halt               : core control
//   done/timed_out/busy/cycle_count/state_o   : status to the MMIO read side
//
// state       | meaning
// IDLE        | core held in reset, waiting for go
// CORE_RST    | reset hold, down-counting RST_CYCLES
// LOAD_REQ    | DMA request raised, waiting for ack
// LOAD_WAIT   | DMA accepted, waiting for dma_done
// WAIT_UNHALT | core out of reset, waiting for unhalt
// RUN         | core executing, cycles counted
// PAUSE       | unhalt dropped, count frozen
// DONE        | halted or timed out, results held
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 16,
  parameter int CNT_WIDTH  = 48,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic                  soft_reset,
  input  logic                  unhalt,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [SIZE_WIDTH-1:0] prog_size,
  run_ctrl_if.master            dma,
  output logic                  core_rst,
  output logic                  core_run,
  input  logic                  core_halt,
  output logic                  done,
  output logic                  timed_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [2:0]            state_o
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  run_state_e            state, state_d;
  logic [RST_W-1:0]      rst_cnt, rst_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SIZE_WIDTH-1:0] size_q;
  logic                  to_q, to_d;
  logic                  start;
  logic                  limit_hit;

  // >= rather than == so a run paused exactly on the limit still ends
  // on its first cycle back in RUN.
  assign limit_hit = TO_EN && (cycle_count >= TO_LAST);

  always_comb begin
    state_d   = state;
    rst_cnt_d = rst_cnt;
    to_d      = to_q;
    start     = 1'b0;
    if (soft_reset) begin
      state_d = IDLE;
      to_d    = 1'b0;
    end else if (go && (state == IDLE || state == DONE)) begin
      state_d   = CORE_RST;
      rst_cnt_d = RST_LOAD;
      to_d      = 1'b0;
      start     = 1'b1;
    end else begin
      case (state)
        CORE_RST: begin
          rst_cnt_d = rst_cnt - 1'b1;
          if (rst_cnt <= RST_W'(1))
            state_d = (size_q == '0) ? WAIT_UNHALT : LOAD_REQ;
        end
        LOAD_REQ:    if (dma.dma_ack) state_d = LOAD_WAIT;
        LOAD_WAIT:   if (dma.dma_done) state_d = WAIT_UNHALT;
        WAIT_UNHALT: if (unhalt) state_d = RUN;
        RUN: begin
          if (core_halt)
            state_d = DONE;
          else if (!unhalt)
            state_d = PAUSE;
          else if (limit_hit) begin
            state_d = DONE;
            to_d    = 1'b1;
          end
        end
        PAUSE:       if (unhalt) state_d = RUN;
        default:     state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rst_cnt <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_d;
      rst_cnt <= rst_cnt_d;
      to_q    <= to_d;
      if (start) begin
        addr_q <= start_addr;
        size_q <= prog_size;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (soft_reset | start),
    .en    (state == RUN),
    .count (cycle_count)
  );

  assign core_rst     = (state == IDLE) || (state == CORE_RST) ||
                        (state == LOAD_REQ) || (state == LOAD_WAIT);
  assign core_run     = (state == RUN);
  assign done         = (state == DONE);
  assign timed_out    = to_q;
  assign busy         = (state != IDLE) && (state != DONE);
  assign state_o      = state;
  assign dma.dma_req  = (state == LOAD_REQ);
  assign dma.dma_addr = addr_q;
  assign dma.dma_size = size_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl (RST_CYCLES=8, TIMEOUT=50).
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int AW = 64;
  localparam int SW = 16;
  localparam int CW = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          go = 1'b0, soft_reset = 1'b0, unhalt = 1'b0, core_halt = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [SW-1:0] prog_size = '0;
  logic          core_rst, core_run, done, timed_out, busy;
  logic [CW-1:0] cycle_count;
  logic [2:0]    state_o;

  run_ctrl_if #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dma ();

  run_ctrl #(
    .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .CNT_WIDTH(CW),
    .RST_CYCLES(8), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .soft_reset(soft_reset), .unhalt(unhalt),
    .start_addr(start_addr), .prog_size(prog_size), .dma(dma.master),
    .core_rst(core_rst), .core_run(core_run), .core_halt(core_halt),
    .done(done), .timed_out(timed_out), .busy(busy),
    .cycle_count(cycle_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [5:0] in;   // {go, soft_reset, unhalt, dma_ack, dma_done, core_halt}
    int         n;    // cycles to hold these inputs
    run_state_e st;
    logic [4:0] out;  // {core_rst, core_run, dma_req, done, busy}
    int         cnt;  // expected cycle_count, -1 = don't care
  } vec_t;

  function automatic vec_t mk(input logic [5:0] in, input int n, input run_state_e st,
                              input logic [4:0] out, input int cnt);
    vec_t v;
    v.in = in; v.n = n; v.st = st; v.out = out; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE or DONE: start a run and return on the first RUN cycle.
  task automatic to_run(input logic [AW-1:0] addr, input logic [SW-1:0] size);
    start_addr = addr;
    prog_size  = size;
    unhalt     = 1'b1;
    go         = 1'b1;
    step();
    go = 1'b0;
    if (size != '0) begin
      for (int i = 0; i < 40 && !dma.dma_req; i++) step();
      chk("to_run_req", 64'(dma.dma_req), 64'(1));
      dma.dma_ack = 1'b1;
      step();
      dma.dma_ack = 1'b0;
      step();
      dma.dma_done = 1'b1;
      step();
      dma.dma_done = 1'b0;
    end
    for (int i = 0; i < 40 && !core_run; i++) step();
    chk("to_run_run", 64'(core_run), 64'(1));
    chk("to_run_cnt0", 64'(cycle_count), 64'(0));
  endtask

  vec_t tv[11];
  logic [63:0] c0;
  int  steps;
  logic any_req;

  initial begin
    dma.dma_ack  = 1'b0;
    dma.dma_done = 1'b0;

    tv[0]  = mk(6'b100000,  1, CORE_RST,    5'b10001,  0);
    tv[1]  = mk(6'b000000,  7, CORE_RST,    5'b10001,  0);
    tv[2]  = mk(6'b000000,  1, LOAD_REQ,    5'b10101,  0);
    tv[3]  = mk(6'b000000,  1, LOAD_REQ,    5'b10101,  0);
    tv[4]  = mk(6'b000100,  1, LOAD_WAIT,   5'b10001,  0);
    tv[5]  = mk(6'b000000,  4, LOAD_WAIT,   5'b10001,  0);
    tv[6]  = mk(6'b000010,  1, WAIT_UNHALT, 5'b00001,  0);
    tv[7]  = mk(6'b001000,  1, RUN,         5'b01001,  0);
    tv[8]  = mk(6'b001000, 19, RUN,         5'b01001, -1);
    tv[9]  = mk(6'b001001,  1, DONE,        5'b00010, 20);
    tv[10] = mk(6'b001000,  2, DONE,        5'b00010, 20);

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 64'(state_o), 64'(IDLE));
    chk("rst_core_rst", 64'(core_rst), 64'(1));
    chk("rst_outs", 64'({core_run, done, timed_out, busy, dma.dma_req}), 64'(0));
    chk("rst_cnt", 64'(cycle_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic run, table driven
    start_addr = 64'h1000;
    prog_size  = 16'd4;
    for (int i = 0; i < 11; i++) begin
      {go, soft_reset, unhalt, dma.dma_ack, dma.dma_done, core_halt} = tv[i].in;
      for (int k = 0; k < tv[i].n; k++) begin
        step();
        if (k == 0) go = 1'b0;
        chk($sformatf("v%0d_%0d_state", i, k), 64'(state_o), 64'(tv[i].st));
        chk($sformatf("v%0d_%0d_outs", i, k),
            64'({core_rst, core_run, dma.dma_req, done, busy}), 64'(tv[i].out));
        if (tv[i].cnt >= 0)
          chk($sformatf("v%0d_%0d_cnt", i, k), 64'(cycle_count), 64'(tv[i].cnt));
        if (dma.dma_req) begin
          chk("basic_dma_addr", dma.dma_addr, 64'h1000);
          chk("basic_dma_size", 64'(dma.dma_size), 64'(4));
        end
      end
    end
    {dma.dma_ack, dma.dma_done, core_halt} = 3'b000;
    chk("basic_timed_out", 64'(timed_out), 64'(0));

    // Pause
    to_run(64'h2000, 16'd8);
    repeat (5) step();
    chk("pause_pre_cnt", 64'(cycle_count), 64'(5));
    unhalt = 1'b0;
    step();
    chk("pause_state", 64'(state_o), 64'(PAUSE));
    chk("pause_entry_cnt", 64'(cycle_count), 64'(6));
    for (int i = 0; i < 9; i++) begin
      step();
      chk("pause_run_low", 64'(core_run), 64'(0));
      chk("pause_frozen", 64'(cycle_count), 64'(6));
    end
    unhalt = 1'b1;
    step();
    chk("pause_resume", 64'(state_o), 64'(RUN));
    core_halt = 1'b1;
    step();
    core_halt = 1'b0;
    chk("pause_done", 64'(done), 64'(1));
    chk("pause_final_cnt", 64'(cycle_count), 64'(7));

    // Timeout
    to_run(64'h4000, 16'd1);
    steps = 0;
    while (!done && steps < 200) begin
      step();
      steps++;
    end
    chk("to_done", 64'(done), 64'(1));
    chk("to_timed_out", 64'(timed_out), 64'(1));
    chk("to_cnt", 64'(cycle_count), 64'(50));
    chk("to_cycles", 64'(steps), 64'(50));

    // Halt and timeout on the same cycle
    to_run(64'h5000, 16'd2);
    chk("toh_cleared", 64'(timed_out), 64'(0));
    repeat (49) step();
    chk("toh_pre", 64'(state_o), 64'(RUN));
    core_halt = 1'b1;
    step();
    core_halt = 1'b0;
    chk("toh_done", 64'(done), 64'(1));
    chk("toh_timed_out", 64'(timed_out), 64'(0));
    chk("toh_cnt", 64'(cycle_count), 64'(50));

    // Soft reset mid-load with a coincident go
    start_addr = 64'h6000;
    prog_size  = 16'd3;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int i = 0; i < 40 && !dma.dma_req; i++) step();
    chk("sr_req", 64'(dma.dma_req), 64'(1));
    dma.dma_ack = 1'b1;
    step();
    dma.dma_ack = 1'b0;
    chk("sr_load_wait", 64'(state_o), 64'(LOAD_WAIT));
    soft_reset = 1'b1;
    go = 1'b1;
    step();
    soft_reset = 1'b0;
    go = 1'b0;
    chk("sr_idle", 64'(state_o), 64'(IDLE));
    chk("sr_req_low", 64'(dma.dma_req), 64'(0));
    chk("sr_core_rst", 64'(core_rst), 64'(1));
    dma.dma_done = 1'b1;
    step();
    dma.dma_done = 1'b0;
    chk("sr_late_done", 64'(state_o), 64'(IDLE));

    // Restart from DONE with zero size
    to_run(64'h7000, 16'd2);
    core_halt = 1'b1;
    step();
    core_halt = 1'b0;
    chk("zs_in_done", 64'(done), 64'(1));
    unhalt = 1'b0;
    prog_size = '0;
    go = 1'b1;
    step();
    go = 1'b0;
    chk("zs_done_clr", 64'(done), 64'(0));
    chk("zs_cnt_clr", 64'(cycle_count), 64'(0));
    any_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      any_req |= dma.dma_req;
    end
    chk("zs_still_rst", 64'(state_o), 64'(CORE_RST));
    step();
    any_req |= dma.dma_req;
    chk("zs_wait_unhalt", 64'(state_o), 64'(WAIT_UNHALT));
    chk("zs_no_req", 64'(any_req), 64'(0));

    // Asynchronous reset mid-run
    unhalt = 1'b1;
    step();
    chk("ar_run", 64'(state_o), 64'(RUN));
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 64'(state_o), 64'(IDLE));
    chk("ar_core_rst", 64'(core_rst), 64'(1));
    chk("ar_outs", 64'({core_run, done, timed_out, busy, dma.dma_req}), 64'(0));
    chk("ar_cnt", 64'(cycle_count), 64'(0));
    chk("ar_addr", dma.dma_addr, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_after", 64'(state_o), 64'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
